cache_arbiter: RTL and testbench

- Two-port arbiter that shares one l2_cache line port (256-bit, 32-bit address) between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between the two L1 cache instances and l2_cache.
- Latches the winning request, drives the L2 until it responds, then routes the response back to the winner only.
- Fixed D-over-I priority, with a starvation counter that promotes I after repeated losses.

---
 rtl/cache_arbiter_pkg.sv | 15 +
 rtl/cache_arbiter_grant_logic.sv | 40 ++++
 rtl/cache_arbiter.sv | 155 +++++++++++++++
 tb/tb_cache_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the L1-to-L2 cache arbiter.
// Line/address widths match the l2_cache line port.
package cache_arb_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_grant_logic.sv
// Winner select and starvation-counter next value for cache_arbiter.
// Purely combinational; grants are only produced while in_idle is high.
module arb_grant_logic
  import cache_arb_types::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              in_idle,
  input  logic              req_i,
  input  logic              req_d,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              grant_i,
  output logic              grant_d,
  output logic [WAIT_W-1:0] wait_cnt_nxt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_L = WAIT_W'(MAX_WAIT);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("arb_grant_logic: MAX_WAIT must be in 1..15");
  end

  logic starve;

  always_comb begin
    starve       = req_i && (wait_cnt == MAX_WAIT_L);
    grant_d      = in_idle && req_d && !starve;
    grant_i      = in_idle && req_i && !grant_d;
    wait_cnt_nxt = wait_cnt;
    if (in_idle) begin
      // Any I grant, or I not asking, resets the loss streak.
      if (grant_i || !req_i) begin
        wait_cnt_nxt = '0;
      end else if (grant_d && (wait_cnt < MAX_WAIT_L)) begin
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one l2_cache line port between the L1 I-cache and L1 D-cache.
// Optional statistics counters are enabled by defining CACHE_ARB_STATS_EN.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_i_grants,
  output logic [CNT_W-1:0]  stat_d_grants,
  output logic [CNT_W-1:0]  stat_conflicts
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cache_arbiter: CNT_W must be at least 1");
  end

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              req_i;
  logic              req_d;
  logic              in_idle;
  logic              grant_i;
  logic              grant_d;

  assign req_i   = i_read;
  assign req_d   = d_read | d_write;
  assign in_idle = (state_q == IDLE);

  arb_grant_logic #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .in_idle      (in_idle),
    .req_i        (req_i),
    .req_d        (req_d),
    .wait_cnt     (wait_cnt_q),
    .grant_i      (grant_i),
    .grant_d      (grant_d),
    .wait_cnt_nxt (wait_cnt_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
        end else if (grant_i) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (l2_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant edge: capture the winner's request; hold it until the L2 completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (in_idle) begin
        if (grant_d) begin
          l2_address <= d_address;
          l2_wdata   <= d_wdata;
          l2_write   <= d_write;
          l2_read    <= !d_write;
        end else if (grant_i) begin
          l2_address <= i_address;
          l2_write   <= 1'b0;
          l2_read    <= 1'b1;
        end
      end else if (l2_resp) begin
        l2_read  <= 1'b0;
        l2_write <= 1'b0;
      end
    end
  end

  // Response is routed only to the current owner; data is shared.
  assign i_resp  = l2_resp && (state_q == BUSY_I);
  assign d_resp  = l2_resp && (state_q == BUSY_D);
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

`ifdef CACHE_ARB_STATS_EN
  logic conflict;

  assign conflict = in_idle && req_i && req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (grant_i && (stat_i_grants != '1)) begin
        stat_i_grants <= stat_i_grants + CNT_W'(1);
      end
      if (grant_d && (stat_d_grants != '1)) begin
        stat_d_grants <= stat_d_grants + CNT_W'(1);
      end
      if (conflict && (stat_conflicts != '1)) begin
        stat_conflicts <= stat_conflicts + CNT_W'(1);
      end
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $warning("cache_arbiter: d_read and d_write both high, treated as write");
      assert (!(in_idle && l2_resp))
        else $warning("cache_arbiter: l2_resp while IDLE ignored");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter (stats checks when CACHE_ARB_STATS_EN).
module tb_cache_arbiter;
  import cache_arb_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
`ifdef CACHE_ARB_STATS_EN
  logic [15:0]       stat_i_grants;
  logic [15:0]       stat_d_grants;
  logic [15:0]       stat_conflicts;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [LINE_W-1:0] DATA_A = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] DATA_W = {8{32'h12345678}};
  localparam logic [LINE_W-1:0] DATA_C = {8{32'hCAFEF00D}};
  localparam logic [LINE_W-1:0] DATA_R = {8{32'h0BADF00D}};

  cache_arbiter #(
    .MAX_WAIT (4),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
`ifdef CACHE_ARB_STATS_EN
    ,
    .stat_i_grants  (stat_i_grants),
    .stat_d_grants  (stat_d_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive l2_resp high for the current cycle (resp outputs settle after #1).
  task automatic l2_ack(input logic [LINE_W-1:0] data);
    l2_rdata = data;
    l2_resp  = 1'b1;
    #1;
  endtask

  // Let the completion edge pass and drop l2_resp.
  task automatic l2_done();
    step();
    l2_resp = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    l2_rdata  = '0;
    l2_resp   = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_l2_read", l2_read, 1'b0);
    chk("rst_l2_write", l2_write, 1'b0);
    chk("rst_l2_address", l2_address, '0);
    chk("rst_l2_wdata", l2_wdata, '0);
    chk("rst_i_resp", i_resp, 1'b0);
    chk("rst_d_resp", d_resp, 1'b0);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_wait_cnt", dut.wait_cnt_q, '0);
    rst = 1'b0;
    #1;

    // Lone I read, L2 responds three cycles after l2_read
    i_read    = 1'b1;
    i_address = 32'h0000_1000;
    step();
    chk("t1_l2_read", l2_read, 1'b1);
    chk("t1_l2_write", l2_write, 1'b0);
    chk("t1_l2_address", l2_address, 32'h0000_1000);
    step();
    step();
    chk("t1_i_resp_early", i_resp, 1'b0);
    chk("t1_l2_read_held", l2_read, 1'b1);
    step();
    l2_ack(DATA_A);
    chk("t1_i_resp", i_resp, 1'b1);
    chk("t1_d_resp", d_resp, 1'b0);
    chk("t1_i_rdata", i_rdata, DATA_A);
    i_read = 1'b0;
    l2_done();
    chk("t1_i_resp_after", i_resp, 1'b0);
    chk("t1_l2_read_drop", l2_read, 1'b0);
    chk("t1_state_idle", dut.state_q, IDLE);

    // Simultaneous I read and D write: D first, I after one IDLE cycle
    i_read    = 1'b1;
    i_address = 32'h0000_2000;
    d_write   = 1'b1;
    d_address = 32'h0000_3000;
    d_wdata   = DATA_W;
    step();
    chk("t2_l2_write", l2_write, 1'b1);
    chk("t2_l2_read", l2_read, 1'b0);
    chk("t2_l2_address", l2_address, 32'h0000_3000);
    chk("t2_l2_wdata", l2_wdata, DATA_W);
    chk("t2_wait_cnt", dut.wait_cnt_q, 4'd1);
    l2_ack(DATA_R);
    chk("t2_d_resp", d_resp, 1'b1);
    chk("t2_i_resp_none", i_resp, 1'b0);
    d_write = 1'b0;
    l2_done();
    chk("t2_idle_gap", l2_read | l2_write, 1'b0);
    step();
    chk("t2_i_l2_read", l2_read, 1'b1);
    chk("t2_i_l2_address", l2_address, 32'h0000_2000);
    chk("t2_wait_clear", dut.wait_cnt_q, 4'd0);
    l2_ack(DATA_A);
    chk("t2_i_resp", i_resp, 1'b1);
    chk("t2_d_resp_none", d_resp, 1'b0);
    i_read = 1'b0;
    l2_done();

    // Starvation: D wins four grants, the fifth goes to I
    i_read    = 1'b1;
    i_address = 32'h0000_5000;
    d_read    = 1'b1;
    d_address = 32'h0000_6000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_d_grant_addr", l2_address, 32'h0000_6000);
      chk("t3_d_grant_read", l2_read, 1'b1);
      chk("t3_wait_cnt", dut.wait_cnt_q, 4'(k + 1));
      l2_ack(DATA_R);
      chk("t3_d_resp", d_resp, 1'b1);
      l2_done();
    end
    step();
    chk("t3_i_grant_addr", l2_address, 32'h0000_5000);
    chk("t3_i_grant_state", dut.state_q, BUSY_I);
    chk("t3_wait_clear", dut.wait_cnt_q, 4'd0);
    l2_ack(DATA_A);
    chk("t3_i_resp", i_resp, 1'b1);
    chk("t3_d_resp_none", d_resp, 1'b0);
    i_read = 1'b0;
    l2_done();
    d_read = 1'b0;
    #1;

    // Reset two cycles into BUSY_D abandons the write; held request reissues
    d_write   = 1'b1;
    d_address = 32'h0000_7000;
    d_wdata   = DATA_C;
    step();
    chk("t4_l2_write", l2_write, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("t4_rst_l2_write", l2_write, 1'b0);
    chk("t4_rst_state", dut.state_q, IDLE);
    chk("t4_rst_d_resp", d_resp, 1'b0);
    chk("t4_rst_address", l2_address, '0);
    step();
    rst = 1'b0;
    #1;
    step();
    chk("t4_reissue_write", l2_write, 1'b1);
    chk("t4_reissue_addr", l2_address, 32'h0000_7000);
    chk("t4_reissue_wdata", l2_wdata, DATA_C);
    l2_ack(DATA_R);
    chk("t4_d_resp", d_resp, 1'b1);
    d_write = 1'b0;
    l2_done();

    // d_read and d_write together: write wins
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_4000;
    step();
    chk("t5_l2_write", l2_write, 1'b1);
    chk("t5_l2_read", l2_read, 1'b0);
    chk("t5_l2_address", l2_address, 32'h0000_4000);
    l2_ack(DATA_R);
    chk("t5_d_resp", d_resp, 1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
    l2_done();

`ifdef CACHE_ARB_STATS_EN
    // Statistics: 3 conflict cycles, 3 D grants, 2 I grants after reset
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_rst_conflicts", stat_conflicts, 16'd0);
    i_read    = 1'b1;
    i_address = 32'h0000_8000;
    d_read    = 1'b1;
    d_address = 32'h0000_9000;
    for (int k = 0; k < 3; k++) begin
      step();
      l2_ack(DATA_R);
      if (k == 2) d_read = 1'b0;
      l2_done();
    end
    for (int k = 0; k < 2; k++) begin
      step();
      l2_ack(DATA_A);
      if (k == 1) i_read = 1'b0;
      l2_done();
    end
    step();
    chk("t6_stat_conflicts", stat_conflicts, 16'd3);
    chk("t6_stat_i_grants", stat_i_grants, 16'd2);
    chk("t6_stat_d_grants", stat_d_grants, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
